// File: rtl/instr_stepper.sv
// instr_stepper: six-step one-hot sequencer, instruction register and step-strobe decoder.
// Optional STEP_SINGLE_EN parks in HOLD after S6 until a step_req pulse.
module instr_stepper #(
   parameter int STEPS = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [7:0] bus,
   input  logic [3:0] flags,
`ifdef STEP_SINGLE_EN
   input  logic       step_req,
`endif
   output logic       seq1,
   output logic       seq2,
   output logic       seq3,
   output logic       seq4,
   output logic       seq5,
   output logic       seq6,
   output logic [7:0] ir,
   output logic       cpt4,
   output logic       cpt5,
   output logic       cpt6,
   output logic       LD4,
   output logic       LD5,
   output logic       ST4,
   output logic       ST5,
   output logic       DATA4,
   output logic       DATA5,
   output logic       DATA6,
   output logic       JMPR4,
   output logic       JMP4,
   output logic       JMP5,
   output logic       JCON4,
   output logic       JCON5,
   output logic       JCON6,
   output logic       CLR4,
   output logic       DISP4,
   output logic       halted
);
`ifdef STEP_SINGLE_EN
   typedef enum logic [2:0] {S1 = 3'd0, S2, S3, S4, S5, S6 = 3'(STEPS - 1), HOLD = 3'd6} state_t;
`else
   typedef enum logic [2:0] {S1 = 3'd0, S2, S3, S4, S5, S6 = 3'(STEPS - 1)} state_t;
`endif
   state_t state, next;
   logic [7:0] cls;
   logic s4, s5, s6;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= S1;
         ir    <= 8'h00;
      end else begin
         state <= next;
         if (run && state == S2) ir <= bus;
      end
   always_comb begin
`ifdef STEP_SINGLE_EN
      next = !run ? state : state == HOLD ? (step_req ? S1 : HOLD) : state == S6 ? HOLD : state_t'(state + 3'd1);
      halted = state == HOLD;
`else
      next = !run ? state : state == S6 ? S1 : state_t'(state + 3'd1);
      halted = 1'b0;
`endif
   end
   // cls is the one-hot non-ALU class; empty for ALU ops so classes never overlap
   always_comb begin
      seq1  = state == S1;
      seq2  = state == S2;
      seq3  = state == S3;
      seq4  = state == S4;
      seq5  = state == S5;
      seq6  = state == S6;
      s4    = seq4;
      s5    = seq5;
      s6    = seq6;
      cls   = ir[7] ? 8'h00 : 8'h01 << ir[6:4];
      cpt4  = s4 & ir[7];
      cpt5  = s5 & ir[7];
      cpt6  = s6 & ir[7];
      LD4   = s4 & cls[0];
      LD5   = s5 & cls[0];
      ST4   = s4 & cls[1];
      ST5   = s5 & cls[1];
      DATA4 = s4 & cls[2];
      DATA5 = s5 & cls[2];
      DATA6 = s6 & cls[2];
      JMPR4 = s4 & cls[3];
      JMP4  = s4 & cls[4];
      JMP5  = s5 & cls[4];
      JCON4 = s4 & cls[5];
      JCON5 = s5 & cls[5];
      JCON6 = s6 & cls[5] & |(ir[3:0] & flags);
      CLR4  = s4 & cls[6];
      DISP4 = s4 & cls[7];
   end
endmodule

// File: tb/tb_instr_stepper.sv
// tb_instr_stepper: directed checks of step ring, IR capture, strobe decode, freeze and reset.
module tb_instr_stepper;
   logic clk = 0, rst = 1, run = 0, step_req = 0;
   logic [7:0] bus = 8'h00;
   logic [3:0] flags = 4'h0;
   logic seq1, seq2, seq3, seq4, seq5, seq6, halted;
   logic [7:0] ir;
   logic cpt4, cpt5, cpt6, LD4, LD5, ST4, ST5, DATA4, DATA5, DATA6;
   logic JMPR4, JMP4, JMP5, JCON4, JCON5, JCON6, CLR4, DISP4;
   int n = 0, errs = 0;
   localparam logic [17:0] C4 = 18'd1 << 17, C5 = 18'd1 << 16, C6 = 18'd1 << 15;
   localparam logic [17:0] L4 = 18'd1 << 14, L5 = 18'd1 << 13, T4 = 18'd1 << 12, T5 = 18'd1 << 11;
   localparam logic [17:0] D4 = 18'd1 << 10, D5 = 18'd1 << 9, D6 = 18'd1 << 8, R4 = 18'd1 << 7;
   localparam logic [17:0] M4 = 18'd1 << 6, M5 = 18'd1 << 5, J4 = 18'd1 << 4, J5 = 18'd1 << 3;
   localparam logic [17:0] J6 = 18'd1 << 2, K4 = 18'd1 << 1, P4 = 18'd1;
   logic [17:0] strb;
   logic [5:0] seq;
   assign strb = {cpt4, cpt5, cpt6, LD4, LD5, ST4, ST5, DATA4, DATA5, DATA6,
                  JMPR4, JMP4, JMP5, JCON4, JCON5, JCON6, CLR4, DISP4};
   assign seq = {seq6, seq5, seq4, seq3, seq2, seq1};
   instr_stepper dut (
      .clk(clk), .rst(rst), .run(run), .bus(bus), .flags(flags),
`ifdef STEP_SINGLE_EN
      .step_req(step_req),
`endif
      .seq1(seq1), .seq2(seq2), .seq3(seq3), .seq4(seq4), .seq5(seq5), .seq6(seq6),
      .ir(ir), .cpt4(cpt4), .cpt5(cpt5), .cpt6(cpt6), .LD4(LD4), .LD5(LD5),
      .ST4(ST4), .ST5(ST5), .DATA4(DATA4), .DATA5(DATA5), .DATA6(DATA6),
      .JMPR4(JMPR4), .JMP4(JMP4), .JMP5(JMP5), .JCON4(JCON4), .JCON5(JCON5),
      .JCON6(JCON6), .CLR4(CLR4), .DISP4(DISP4), .halted(halted)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask
   // advance out of S6 and, in single-step builds, release HOLD
   task automatic wrap();
      step();
`ifdef STEP_SINGLE_EN
      check("hold", {halted, seq}, {1'b1, 6'b0});
      step_req = 1;
      step();
      step_req = 0;
`endif
      check("wrap s1", {halted, seq}, {1'b0, 6'b000001});
   endtask
   task automatic run_instr(input logic [7:0] b, input logic [3:0] f,
                            input logic [17:0] e4, input logic [17:0] e5, input logic [17:0] e6);
      bus = b;
      flags = f;
      check("s1 seq", seq, 6'b000001);
      check("s1 strb", strb, 0);
      step(); check("s2 seq", seq, 6'b000010); check("s2 strb", strb, 0);
      step(); check("s3 seq", seq, 6'b000100); check("s3 strb", strb, 0); check("s3 ir", ir, b);
      step(); check("s4 seq", seq, 6'b001000); check("s4 strb", strb, e4);
      step(); check("s5 seq", seq, 6'b010000); check("s5 strb", strb, e5);
      step(); check("s6 seq", seq, 6'b100000); check("s6 strb", strb, e6);
      wrap();
   endtask
   logic [7:0]  sb [9] = '{8'h00, 8'h10, 8'h20, 8'h3F, 8'h4A, 8'h5F, 8'h63, 8'h7E, 8'hF0};
   logic [17:0] s4 [9] = '{L4, T4, D4, R4, M4, J4, K4, P4, C4};
   logic [17:0] s5 [9] = '{L5, T5, D5, 18'd0, M5, J5, 18'd0, 18'd0, C5};
   logic [17:0] s6 [9] = '{18'd0, 18'd0, D6, 18'd0, 18'd0, J6, 18'd0, 18'd0, C6};
   initial begin
      @(negedge clk);
      check("rst seq", seq, 6'b000001);
      check("rst ir", ir, 8'h00);
      check("rst strb", strb, 0);
      check("rst halted", halted, 0);
      rst = 0;
      run = 1;
      run_instr(8'h81, 4'h0, C4, C5, C6);
      run_instr(8'h81, 4'h0, C4, C5, C6);
      run_instr(8'h5C, 4'b0100, J4, J5, J6);
      run_instr(8'h5C, 4'b0011, J4, J5, 18'd0);
      bus = 8'h10;
      step(); step(); step();
      check("st s4", {seq, strb}, {6'b001000, T4});
      run = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("frz st4", {seq, strb}, {6'b001000, T4});
      end
      run = 1;
      step(); check("st5", {seq, strb}, {6'b010000, T5});
      step(); wrap();
      bus = 8'h00;
      step(); step(); step(); step();
      check("ld5", {seq, strb}, {6'b010000, L5});
      #2 rst = 1;
      #1 check("async rst", {seq, strb, ir}, {6'b000001, 18'd0, 8'h00});
      @(negedge clk);
      rst = 0;
      run_instr(8'h30, 4'h0, R4, 18'd0, 18'd0);
      bus = 8'h70;
      step();
      run = 0;
      bus = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         step();
         check("frz s2 ir", {seq, ir}, {6'b000010, 8'h30});
      end
      bus = 8'h70;
      run = 1;
      step(); check("s2 resume ir", {seq, ir}, {6'b000100, 8'h70});
      step(); check("disp4", strb, P4);
      step(); step(); check("disp s6", strb, 0);
      wrap();
      for (int i = 0; i < 9; i++) run_instr(sb[i], 4'b0001, s4[i], s5[i], s6[i]);
`ifdef STEP_SINGLE_EN
      bus = 8'h81;
      for (int i = 0; i < 6; i++) step();
      for (int i = 0; i < 10; i++) begin
         check("park", {halted, seq, strb}, {1'b1, 6'b0, 18'd0});
         step();
      end
      step_req = 1;
      step();
      step_req = 0;
      check("req s1", {halted, seq}, {1'b0, 6'b000001});
      step(); step();
      step_req = 1;
      step();
      step_req = 0;
      check("req s3 ignored", seq, 6'b001000);
      step(); step(); wrap();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule
